// File: rtl/my_full_adder.sv
// my_full_adder
//   1-bit full adder. The sum and carry outputs are purely combinational.
//   Registered copies and a saturating carry-event counter sit beside them.
//
//   Ports (positional order is fixed, so a five-port positional hookup
//   of sum, carry, a, b, c still works):
//     sum       out  a ^ b ^ c, combinational
//     carry     out  majority(a, b, c), combinational
//     a, b, c   in   addend A, addend B, carry-in
//     clk       in   rising-edge clock for the registered outputs
//     rst       in   synchronous, active-high reset
//     sum_r     out  sum delayed by one clock
//     carry_r   out  carry delayed by one clock
//     carry_cnt out  CNT_W-bit saturating count of edges where carry = 1
//
//   CNT_W legal range: 1..32.
module my_full_adder #(
  parameter int CNT_W = 8
) (
  output logic             sum,
  output logic             carry,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst,
  output logic             sum_r,
  output logic             carry_r,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The combinational path reads only a, b and c. This keeps it valid
  // when clk and rst are left floating.
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

  // Reset is checked first, so a carry event on a reset edge still
  // leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r     <= 1'b0;
      carry_r   <= 1'b0;
      carry_cnt <= '0;
    end else begin
      sum_r   <= sum;
      carry_r <= carry;
      // The counter holds at all-ones instead of wrapping to zero.
      if (carry && (carry_cnt != CNT_MAX))
        carry_cnt <= carry_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_my_full_adder.sv
module tb_my_full_adder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0, b = 1'b0, c = 1'b0;
  logic       sum, carry, sum_r, carry_r;
  logic [7:0] carry_cnt;

  // saturation instance
  logic       s_sum, s_carry, s_sum_r, s_carry_r;
  logic [1:0] s_cnt;

  // positional instance, clock and reset left floating
  logic       p_clk = 1'bz;
  logic       p_rst = 1'bx;
  logic       p_sum, p_carry, p_sum_r, p_carry_r;
  logic [7:0] p_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  my_full_adder #(.CNT_W(8)) dut (
    .sum(sum), .carry(carry), .a(a), .b(b), .c(c), .clk(clk), .rst(rst),
    .sum_r(sum_r), .carry_r(carry_r), .carry_cnt(carry_cnt)
  );

  my_full_adder #(.CNT_W(2)) dut_sat (
    .sum(s_sum), .carry(s_carry), .a(a), .b(b), .c(c), .clk(clk), .rst(rst),
    .sum_r(s_sum_r), .carry_r(s_carry_r), .carry_cnt(s_cnt)
  );

  my_full_adder dut_pos (p_sum, p_carry, a, b, c, p_clk, p_rst,
                         p_sum_r, p_carry_r, p_cnt);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_abc(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    logic [1:0] tt_exp [8];
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // reset state
    set_abc(3'b000);
    rst = 1'b1;
    tick(2);
    chk("rst_sum_r",   {31'd0, sum_r},   32'd0);
    chk("rst_carry_r", {31'd0, carry_r}, 32'd0);
    chk("rst_cnt",     {24'd0, carry_cnt}, 32'd0);
    chk("rst_sat_cnt", {30'd0, s_cnt},   32'd0);

    // truth table, held in reset so sum/carry are seen following inputs
    for (int i = 0; i < 8; i++) begin
      set_abc(3'(i));
      #1;
      chk($sformatf("tt_%0d", i),     {30'd0, carry, sum},     {30'd0, tt_exp[i]});
      chk($sformatf("tt_pos_%0d", i), {30'd0, p_carry, p_sum}, {30'd0, tt_exp[i]});
      #9;
    end
    chk("tt_rst_hold_cnt", {24'd0, carry_cnt}, 32'd0);

    // registered latency
    tick(1);
    rst = 1'b0;
    set_abc(3'b000);
    tick(1);
    set_abc(3'b111);
    #2;
    chk("lat_pre_sum_r",   {31'd0, sum_r},   32'd0);
    chk("lat_pre_carry_r", {31'd0, carry_r}, 32'd0);
    tick(1);
    chk("lat_sum_r",   {31'd0, sum_r},   32'd1);
    chk("lat_carry_r", {31'd0, carry_r}, 32'd1);
    chk("lat_cnt",     {24'd0, carry_cnt}, 32'd1);

    // counting and hold
    rst = 1'b1;
    set_abc(3'b000);
    tick(1);
    rst = 1'b0;
    set_abc(3'b011);
    tick(5);
    chk("cnt_5", {24'd0, carry_cnt}, 32'd5);
    set_abc(3'b001);
    tick(3);
    chk("cnt_hold", {24'd0, carry_cnt}, 32'd5);
    chk("cnt_hold_sum_r", {31'd0, sum_r}, 32'd1);

    // saturation on the 2-bit counter
    rst = 1'b1;
    set_abc(3'b000);
    tick(1);
    rst = 1'b0;
    set_abc(3'b110);
    tick(2);
    chk("sat_2", {30'd0, s_cnt}, 32'd2);
    tick(4);
    chk("sat_3", {30'd0, s_cnt}, 32'd3);
    chk("sat_wide_6", {24'd0, carry_cnt}, 32'd6);

    // reset priority over a carry event
    rst = 1'b1;
    set_abc(3'b000);
    tick(1);
    rst = 1'b0;
    set_abc(3'b011);
    tick(4);
    chk("pri_pre_cnt", {24'd0, carry_cnt}, 32'd4);
    set_abc(3'b111);
    rst = 1'b1;
    #1;
    chk("pri_sum_in_rst",   {31'd0, sum},   32'd1);
    chk("pri_carry_in_rst", {31'd0, carry}, 32'd1);
    tick(1);
    chk("pri_cnt",     {24'd0, carry_cnt}, 32'd0);
    chk("pri_sum_r",   {31'd0, sum_r},     32'd0);
    chk("pri_carry_r", {31'd0, carry_r},   32'd0);
    chk("pri_sum",     {31'd0, sum},       32'd1);
    chk("pri_carry",   {31'd0, carry},     32'd1);
    rst = 1'b0;
    tick(1);
    chk("pri_resume_cnt", {24'd0, carry_cnt}, 32'd1);

    $display("positional instance registered outs (floating clock): %b %b %0h",
             p_sum_r, p_carry_r, p_cnt);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/my_full_adder.md
MY_FULL_ADDER -- requirements
Module: my_full_adder

Interface
REQ-001 The parameter CNT_W, default 8, SHALL set the width of the carry-event counter, legal range 1..32.
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the single rising-edge clock for all registered outputs.
REQ-003 The port rst SHALL be an input, 1 bit wide, acting as a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 The port sum SHALL be an output, 1 bit wide, carrying the combinational sum bit.
REQ-005 The port carry SHALL be an output, 1 bit wide, carrying the combinational carry-out bit.
REQ-006 The port a SHALL be an input, 1 bit wide, serving as addend A.
REQ-007 The port b SHALL be an input, 1 bit wide, serving as addend B.
REQ-008 The port c SHALL be an input, 1 bit wide, serving as the carry-in.
REQ-009 The port sum_r SHALL be an output, 1 bit wide, carrying sum registered one cycle.
REQ-010 The port carry_r SHALL be an output, 1 bit wide, carrying carry registered one cycle.
REQ-011 The port carry_cnt SHALL be an output, CNT_W bits wide, holding a saturating count of cycles in which carry was 1.
REQ-012 The positional port order SHALL be: sum, carry, a, b, c, clk, rst, sum_r, carry_r, carry_cnt, so that a five-port positional instantiation (sum, carry, a, b, c) connects correctly.

Function
REQ-013 sum SHALL equal a XOR b XOR c, combinationally, with zero cycles of latency.
REQ-014 carry SHALL equal (a AND b) OR (a AND c) OR (b AND c), combinationally.
REQ-015 Together, {carry, sum} SHALL equal the 2-bit arithmetic sum a + b + c for all 8 input combinations.
REQ-016 sum and carry SHALL NOT depend on clk, rst, or any internal state, and SHALL remain correct when clk and rst are unconnected (X/Z).
REQ-017 sum and carry SHALL settle within one delta of an input change, with no glitch-dependent behaviour and no latches.
REQ-018 On each rising edge of clk with rst=0, sum_r SHALL load sum and carry_r SHALL load carry, giving 1-cycle latency.
REQ-019 On each rising edge of clk with rst=0 and carry=1, carry_cnt SHALL increment by 1.
REQ-020 carry_cnt SHALL saturate at 2^CNT_W-1 and hold that value on further carry events without wrapping to 0.
REQ-021 carry_cnt SHALL hold its value on any rising edge where carry=0.
REQ-022 The registered outputs sum_r, carry_r and carry_cnt SHALL change only on rising edges of clk.

Reset
REQ-023 When rst=1 at a rising edge of clk, sum_r, carry_r and carry_cnt SHALL all be 0 after that edge.
REQ-024 Reset SHALL take priority over a simultaneous carry event, so that carry_cnt becomes 0 rather than incrementing.
REQ-025 Reset SHALL NOT affect sum or carry; these SHALL continue to follow a, b and c while rst=1.
REQ-026 Asserting reset mid-count SHALL clear carry_cnt on the next rising edge, and counting SHALL resume from 0 on the first edge after rst returns to 0.
REQ-027 Before the first reset, the registered outputs MAY be X; reset SHALL be applied before they are checked.

Verification
REQ-028 The bench SHALL cover the exhaustive truth table: apply abc = 000,001,010,011,100,101,110,111 with 10-time-unit spacing and check {carry,sum} = 00,01,01,10,01,10,10,11 respectively.
REQ-029 The bench SHALL cover unconnected clocking: instantiate positionally with only (sum,carry,a,b,c) connected and check that the truth table in REQ-028 still passes.
REQ-030 The bench SHALL cover registered latency: with rst=0, set abc=111 before an edge and check that sum_r=1 and carry_r=1 after that edge, with both values unchanged before it.
REQ-031 The bench SHALL cover counting: after reset, hold abc=011 for 5 edges and check carry_cnt=5, then hold abc=001 for 3 edges and check carry_cnt still =5.
REQ-032 The bench SHALL cover saturation: with CNT_W=2, hold abc=110 for 6 edges and check carry_cnt=3.
REQ-033 The bench SHALL cover reset priority: with carry_cnt=4 and abc=111, assert rst for 1 edge and check carry_cnt=0, sum_r=0, carry_r=0, while sum=1 and carry=1 throughout.
